// File: rtl/adder4b_accum_if.sv
// rtl/adder4b_accum_if.sv - operand/result stream and control bundle for adder4b_accum
interface adder4b_accum_if;
  localparam int N_MAX = 15;

  logic                           start;
  logic [$clog2(N_MAX+1)-1:0]     count;
  logic                           in_valid;
  logic                           in_ready;
  logic [3:0]                     in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [3:0]                     sum;
  logic                           ovf;
  logic                           busy;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, ovf, busy
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, ovf, busy
  );
endinterface

// File: rtl/adder4b_accum.sv
// rtl/adder4b_accum.sv - counted mod-16 accumulator over a 4-bit adder with sticky carry
module adder4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] c_o
);
  assign c_o = a_i + b_i;
endmodule

module adder4b_accum (
  input  logic            clk_i,
  input  logic            rst_i,
  adder4b_accum_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic       ovf_q, ovf_d;
  logic [3:0] add_c;
  logic       carry;
  logic       xfer;

  adder4bit u_add (
    .a_i (bus.in_data),
    .b_i (acc_q),
    .c_o (add_c)
  );

  // carry-out is taken from a widened compare rather than the 4-bit adder
  assign carry = ({1'b0, bus.in_data} + {1'b0, acc_q}) > 5'd15;
  assign xfer  = (state_q == ACCUM) && bus.in_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      rem_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = 4'd0;
          ovf_d = 1'b0;
          if (bus.count == 4'd0) begin
            state_d = DONE;
          end else begin
            rem_d   = bus.count;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d = add_c;
          ovf_d = ovf_q | carry;
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = acc_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder4b_accum.sv
// tb/tb_adder4b_accum.sv - randomized self-checking bench for adder4b_accum
module tb_adder4b_accum;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [3:0] opv [16];

  always #5 clk = ~clk;

  adder4b_accum_if bus ();

  adder4b_accum dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run: start, feed opv[0..n-1] with optional stalls, hold result, accept.
  task automatic run(input int n, input int gap, input bit fixed_gap, input int holdmax);
    int true_sum;
    int g;
    int h;
    true_sum = 0;
    bus.start    = 1'b1;
    bus.count    = 4'(n);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'($urandom);
    step();
    bus.start    = 1'b0;
    bus.count    = 4'($urandom);
    bus.in_valid = 1'b0;
    if (n == 0) begin
      chk("zero_out_valid", bus.out_valid, 1);
    end else begin
      chk("start_in_ready", bus.in_ready, 1);
      chk("start_busy", bus.busy, 1);
      chk("start_no_out_valid", bus.out_valid, 0);
    end
    for (int i = 0; i < n; i++) begin
      g = fixed_gap ? gap : ((gap > 0) ? int'($urandom_range(gap, 0)) : 0);
      for (int j = 0; j < g; j++) begin
        step();
        chk("stall_in_ready", bus.in_ready, 1);
        chk("stall_acc", bus.sum, true_sum % 16);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = opv[i];
      true_sum    += int'(opv[i]);
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = 4'($urandom);
      if (i < n - 1) begin
        chk("mid_in_ready", bus.in_ready, 1);
        chk("mid_no_out_valid", bus.out_valid, 0);
      end
    end
    chk("done_out_valid", bus.out_valid, 1);
    chk("done_in_ready", bus.in_ready, 0);
    chk("done_busy", bus.busy, 1);
    chk("done_sum", bus.sum, true_sum % 16);
    chk("done_ovf", bus.ovf, (true_sum >= 16) ? 1 : 0);
    h = (holdmax > 0) ? int'($urandom_range(holdmax, 0)) : 0;
    for (int j = 0; j < h; j++) begin
      bus.start    = j[0] ? 1'b0 : 1'b1;
      bus.count    = 4'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'($urandom);
      step();
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_sum", bus.sum, true_sum % 16);
      chk("hold_ovf", bus.ovf, (true_sum >= 16) ? 1 : 0);
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("accept_out_valid", bus.out_valid, 0);
    chk("accept_busy", bus.busy, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.count     = 4'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_busy", bus.busy, 0);

    opv[0] = 4'd4; opv[1] = 4'd2;
    run(2, 0, 1'b0, 0);
    opv[0] = 4'd5; opv[1] = 4'd7;
    run(2, 0, 1'b0, 0);
    opv[2] = 4'd9;
    run(3, 0, 1'b0, 0);
    opv[0] = 4'd1; opv[1] = 4'd2; opv[2] = 4'd3;
    run(3, 4, 1'b1, 0);
    run(0, 0, 1'b0, 5);

    // reset in the middle of an accumulation
    bus.start = 1'b1;
    bus.count = 4'd4;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd15;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    opv[0] = 4'd9;
    run(1, 0, 1'b0, 0);

    // back-to-back: overflowing run followed immediately by a clean one
    opv[0] = 4'd15; opv[1] = 4'd15; opv[2] = 4'd3;
    run(3, 0, 1'b0, 0);
    opv[0] = 4'd1; opv[1] = 4'd2;
    run(2, 0, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      int n;
      n = int'($urandom_range(15, 0));
      for (int i = 0; i < 16; i++) opv[i] = 4'($urandom);
      run(n, 2, 1'b0, 3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/adder4b_accum.md
# adder4b_accum

Sequential accumulator built around the 4-bit adder (`adder4bit`). Sits directly downstream of it: it owns the adder's `B` operand register and captures the adder's `C` result every accepted beat. It sums a programmed number of 4-bit operands arriving over a valid/ready stream and presents the modulo-16 total, plus a sticky overflow flag, on a valid/ready output port.

## Interface
- `N_MAX`, 15: largest operand count accepted. `count` is 4 bits wide, so the legal range is 0..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `count`  in  4  number of operands to sum; latched on the `start` cycle.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts an operand; registered, high only in ACCUM.
- `in_data`  in  4  operand.
- `out_valid`  out  1  `sum`/`ovf` valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  4  accumulated total mod 16; holds its value while `out_valid` is high.
- `ovf`  out  1  sticky: set if any addition carried out of bit 3.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Datapath: one `adder4bit` instance with A = `in_data`, B = `acc`, next `acc` = C, computed as (A+B) mod 16.
- Carry comes from a separate 5-bit compare: `ovf` is set when `acc`+`in_data` ≥ 16.
- Register `rem` (4 bits) tracks the operands still expected.
- FSM states: IDLE, ACCUM, DONE.
- IDLE, with `start`=1 and `count`≠0: `acc`←0, `ovf`←0, `rem`←`count`, go to ACCUM.
- IDLE, with `start`=1 and `count`=0: `acc`←0, `ovf`←0, go directly to DONE. Result is `sum`=0, `ovf`=0.
- IDLE, with `start`=0: hold state.
- ACCUM, on a transfer (`in_valid`&&`in_ready`): `acc`←C, `ovf`←`ovf`|carry, `rem`←`rem`−1. If `rem`==1, go to DONE.
- ACCUM, with no transfer: all state holds. A stall of any length is legal.
- DONE: `out_valid`=1 and `sum`=`acc`. When `out_valid`&&`out_ready`, go to IDLE.
- `start` is ignored in ACCUM and DONE; it does not queue.
- `count` is ignored outside the `start` cycle.
- `rst` in any state, including mid-accumulation or with a result pending: next cycle state=IDLE and all registers cleared. The partial sum is discarded.
- Reset values: `in_ready`=0, `out_valid`=0, `sum`=0, `ovf`=0, `busy`=0, `acc`=0, `rem`=0.
- `in_data`/`in_valid` presented outside ACCUM are ignored. They do not affect `acc`.

## Timing
- All outputs are registered or decoded from state; there are no combinational input→output paths.
- `start` at edge t (IDLE): `in_ready`=1 and `busy`=1 from cycle t+1.
- Throughput: one operand per cycle while `in_valid` is held high.
- Last operand accepted at edge k: `in_ready`=0 and `out_valid`=1 from cycle k+1, with `sum` final.
- Minimum latency for `count`=n with no stalls: n+1 cycles from `start` to `out_valid`.
- `count`=0: `out_valid`=1 at t+1.
- Result accepted at edge m: `out_valid`=0 and `busy`=0 at m+1. A new `start` is accepted at edge m+1 or later.
- `rst` has priority over every other input on the same edge.

## Test plan
- Reset, then `start`, `count`=2, operands 4, 2 → `out_valid` 3 cycles after `start`, `sum`=6, `ovf`=0.
- `count`=2, operands 5, 7, then 5, 7, 9 with `count`=3 in a second run → first run `sum`=12, `ovf`=0; second run `sum`=5 (21 mod 16), `ovf`=1.
- `count`=3, operands 1, 2, 3 with `in_valid` dropped for 4 cycles between beats → `sum`=6; `in_ready` stays high through the gaps; `acc` unchanged during stalls.
- `count`=0 → `out_valid` at t+1 with `sum`=0, `ovf`=0; `out_ready` held low 5 cycles keeps `out_valid`/`sum` stable; a `start` pulse during DONE is ignored.
- `count`=4, assert `rst` after 2 operands (15, 15) → next cycle IDLE, `ovf`=0, `sum`=0, `busy`=0; a fresh run with `count`=1, operand 9 gives `sum`=9, `ovf`=0.
- Back-to-back runs: `out_ready` tied high, `start` at edge m+1 → second result correct; the first run's `ovf`=1 does not leak into the second.
